// File: rtl/bk_nibble_serial_adder_if.sv
// Operand/result handshake bundle for bk_nibble_serial_adder.
// The producer/consumer side uses master; the adder uses slave.
`timescale 1ns/1ps
interface bk_nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/bk_nibble_serial_adder.sv
// Nibble-serial wide adder: one 4-bit Brent-Kung add per cycle, carry registered between nibbles.
// Optional macro BK_ACCUM_EN turns the B operand into an internal accumulator with an acc_clr input.
`timescale 1ns/1ps
module bk_nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef BK_ACCUM_EN
  input  logic                      acc_clr,
`endif
  bk_nibble_serial_adder_if.slave   bus,
  output logic                      busy
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_op;
  logic [W-1:0]     sum_q;
  logic             cout_q;
  logic [3:0]       nib_a, nib_b;
  logic [4:0]       nib_sum;
  logic             accept, hand_off, last_nib;

  // 4-bit Brent-Kung prefix adder with carry-in; returns {cout, sum[3:0]}.
  function automatic logic [4:0] bk_add4(input logic [3:0] a, input logic [3:0] b,
                                         input logic cin);
    logic [3:0] g, p;
    logic       g10, p10, g32, p32, g30, p30, g20, p20;
    logic [4:0] c;
    g   = a & b;
    p   = a ^ b;
    g10 = g[1] | (p[1] & g[0]);
    p10 = p[1] & p[0];
    g32 = g[3] | (p[3] & g[2]);
    p32 = p[3] & p[2];
    g30 = g32 | (p32 & g10);
    p30 = p32 & p10;
    g20 = g[2] | (p[2] & g10);
    p20 = p[2] & p10;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g10 | (p10 & cin);
    c[3] = g20 | (p20 & cin);
    c[4] = g30 | (p30 & cin);
    return {c[4], p ^ c[3:0]};
  endfunction

`ifdef BK_ACCUM_EN
  logic [W-1:0] acc_q;
  logic         unused_in_b;
  assign unused_in_b = ^bus.in_b;
  assign b_op        = acc_q;
  // A clear request wins over an operand in the same cycle, so do not advertise ready.
  assign bus.in_ready = (state_q == IDLE) && !acc_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc_q <= '0;
    else if (acc_clr && (state_q == IDLE))
      acc_q <= '0;
    else if (hand_off)
      acc_q <= sum_q;
  end
`else
  logic [W-1:0] b_q;
  assign b_op         = b_q;
  assign bus.in_ready = (state_q == IDLE);
`endif

  assign accept        = bus.in_valid && bus.in_ready;
  assign hand_off      = bus.out_valid && bus.out_ready;
  assign last_nib      = (idx_q == IDX_W'(NIBBLES - 1));
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign busy          = (state_q != IDLE);

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_op[4*i +: 4];
      end
    end
  end

  assign nib_sum = bk_add4(nib_a, nib_b, carry_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)   state_d = RUN;
      RUN:     if (last_nib) state_d = DONE;
      DONE:    if (hand_off) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Capture on acceptance, then fold in one nibble per cycle; DONE and IDLE hold the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
`ifndef BK_ACCUM_EN
      b_q     <= '0;
`endif
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= bus.in_a;
`ifndef BK_ACCUM_EN
            b_q     <= bus.in_b;
`endif
            carry_q <= bus.in_cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) sum_q[4*i +: 4] <= nib_sum[3:0];
          end
          carry_q <= nib_sum[4];
          idx_q   <= idx_q + 1'b1;
          if (last_nib) cout_q <= nib_sum[4];
        end
        default: ;
      endcase
    end
  end
endmodule
